alu_frame_sequencer: RTL and testbench
======================================

# alu_frame_sequencer

Byte-frame sequencer sitting between the UART receiver/transmitter and the ALU on the Basys3 design. Collects three received bytes (operand A, operand B, opcode) and validates the opcode. Drives the registered operands and opcode into the shared ALU, captures the result and hands it to the UART transmitter with a start/done handshake. Owns all frame sequencing so the ALU stays purely combinational.

## Interface
- NB_DATA, 8, operand/result/byte width
- NB_OP, 6, opcode width (low bits of opcode byte)
- TIMEOUT_CYCLES, 100000, inter-byte timeout in clock cycles (used only with ALU_SEQ_TIMEOUT_EN)

- i_clock  in  1  system clock, all state on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_rx_data  in  NB_DATA  received byte
- i_rx_valid  in  1  one-cycle pulse, i_rx_data valid
- o_alu_a  out  NB_DATA  registered operand A to ALU
- o_alu_b  out  NB_DATA  registered operand B to ALU
- o_alu_op  out  NB_OP  registered opcode to ALU
- i_alu_result  in  NB_DATA  combinational ALU result
- o_tx_data  out  NB_DATA  result byte to transmitter, held until next result
- o_tx_start  out  1  one-cycle transmit request
- i_tx_done  in  1  one-cycle pulse, transmitter finished
- o_busy  out  1  high in EXEC, SEND, WAIT_TX
- o_op_error  out  1  sticky invalid-opcode flag
- o_timeout  out  1  one-cycle pulse on frame abort by timeout

## Operation
- States: IDLE (await A), WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- IDLE + i_rx_valid: latch byte into o_alu_a, clear o_op_error, go WAIT_B.
- WAIT_B + i_rx_valid: latch into o_alu_b, go WAIT_OP.
- WAIT_OP + i_rx_valid: the opcode is valid iff byte[7:6]==0 and byte[5:0] is one of ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, SRA 0x03, SRL 0x02, NOR 0x27.
  - Valid: latch byte[5:0] into o_alu_op, go EXEC.
  - Invalid: set o_op_error, leave o_alu_op unchanged, go IDLE; no transmission.
- EXEC: capture i_alu_result into o_tx_data, go SEND.
- SEND: assert o_tx_start, go WAIT_TX.
- WAIT_TX: on i_tx_done go IDLE. i_tx_done in any other state is ignored.
- i_rx_valid in EXEC/SEND/WAIT_TX: byte dropped; the frame does not advance.
- Reset (asynchronous, mid-operation included): state IDLE. All outputs 0: o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_op_error, o_timeout. Timeout counter 0.

## Timing
- Operand/opcode registers update on the edge that samples i_rx_valid and are visible the following cycle.
- Opcode accepted at edge k:
  - Edge k+1: result captured into o_tx_data, state SEND.
  - Cycle k+1..k+2: o_tx_start high for exactly one cycle.
  - Edge k+2: WAIT_TX.
- i_tx_done sampled at edge m in WAIT_TX → IDLE at m. The earliest next A byte is accepted at edge m+1.
- o_busy is decoded from the state register, with no extra latency.
- No back-to-back frames without i_tx_done; the sequencer never issues a second o_tx_start before i_tx_done.

## Configuration
- ALU_SEQ_TIMEOUT_EN defined:
  - Counter runs in WAIT_B and WAIT_OP.
  - Cleared on every accepted byte and on entering IDLE.
  - When it reaches TIMEOUT_CYCLES without i_rx_valid: go IDLE and pulse o_timeout for one cycle. Partial operands are discarded; o_alu_a/o_alu_b keep their last values.
  - An i_rx_valid in the same cycle as expiry wins: the byte is accepted, with no timeout.
- Undefined: no counter is synthesized, o_timeout tied to 0, and a partial frame waits indefinitely.

## Test plan
- A=0x07, B=0x05, op=0x20 with ALU model → o_alu_op=0x20, single o_tx_start pulse 2 cycles after op, o_tx_data=0x0C; i_tx_done → o_busy=0.
- A=0x80, B=0x02, op=0x03 (SRA) → o_tx_data=0xE0; same frame with op=0x02 (SRL) → 0x20.
- A=0x10, B=0x01, op=0x01 (invalid) → o_op_error=1, no o_tx_start, state IDLE; next byte 0x33 → o_alu_a=0x33, o_op_error=0.
- Byte 0x55 pulsed during WAIT_TX → dropped; after i_tx_done, the next frame 0x01, 0x02, 0x20 → o_tx_data=0x03.
- With ALU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100: send A=0x09, then idle 100 cycles → o_timeout one pulse, IDLE. Next byte is taken as A. Without the macro, no abort after 1000 cycles.
- Assert i_reset low while in WAIT_TX → o_busy, o_tx_start, o_tx_data go 0 without waiting for a clock edge; after release, the full ADD frame completes normally.

Source files
------------

// File: rtl/alu_frame_sequencer.sv
// Byte-frame sequencer: collects A, B and opcode bytes, drives the ALU and hands the result to
// the UART transmitter. Optional inter-byte timeout is enabled with ALU_SEQ_TIMEOUT_EN.
module alu_frame_sequencer #(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OP          = 6,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_op_error,
  output logic               o_timeout
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitB,
    StWaitOp,
    StExec,
    StSend,
    StWaitTx
  } state_e;

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] alu_a_q, alu_b_q, tx_data_q;
  logic [NB_OP-1:0]   alu_op_q;
  logic               op_error_q;
  logic               op_valid;
  logic               expire;

  always_comb begin
    op_valid = 1'b0;
    if (i_rx_data[NB_DATA-1:NB_OP] == '0) begin
      case (i_rx_data[NB_OP-1:0])
        NB_OP'('h20), NB_OP'('h22), NB_OP'('h24), NB_OP'('h25),
        NB_OP'('h26), NB_OP'('h03), NB_OP'('h02), NB_OP'('h27): op_valid = 1'b1;
        default: op_valid = 1'b0;
      endcase
    end
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            timeout_q;
  logic            wait_st;

  assign wait_st = (state_q == StWaitB) || (state_q == StWaitOp);
  // A byte arriving in the expiry cycle wins over the timeout.
  assign expire  = wait_st && !i_rx_valid && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!wait_st || i_rx_valid || expire) cnt_q <= '0;
      else                                  cnt_q <= cnt_q + 1'b1;
      timeout_q <= expire;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign expire    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (i_rx_valid) state_d = StWaitB;
      StWaitB:  begin
        if (i_rx_valid)  state_d = StWaitOp;
        else if (expire) state_d = StIdle;
      end
      StWaitOp: begin
        if (i_rx_valid)  state_d = op_valid ? StExec : StIdle;
        else if (expire) state_d = StIdle;
      end
      StExec:   state_d = StSend;
      StSend:   state_d = StWaitTx;
      StWaitTx: if (i_tx_done) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    o_busy     = (state_q == StExec) || (state_q == StSend) || (state_q == StWaitTx);
    o_tx_start = (state_q == StSend);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      op_error_q <= 1'b0;
    end else begin
      if (i_rx_valid) begin
        if (state_q == StIdle) begin
          alu_a_q    <= i_rx_data;
          op_error_q <= 1'b0;
        end else if (state_q == StWaitB) begin
          alu_b_q <= i_rx_data;
        end else if (state_q == StWaitOp) begin
          if (op_valid) alu_op_q   <= i_rx_data[NB_OP-1:0];
          else          op_error_q <= 1'b1;
        end
      end
      if (state_q == StExec) tx_data_q <= i_alu_result;
    end
  end

  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_data  = tx_data_q;
  assign o_op_error = op_error_q;

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Directed bench for alu_frame_sequencer with a behavioural ALU in the loop.
// Define ALU_SEQ_TIMEOUT_EN for both files to exercise the timeout path.
module tb_alu_frame_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] alu_a, alu_b, alu_result, tx_data;
  logic [5:0] alu_op;
  logic       tx_start, tx_done, busy, op_error, timeout;

  int vectors     = 0;
  int miscompares = 0;
  int start_cnt   = 0;

  alu_frame_sequencer #(
    .NB_DATA       (8),
    .NB_OP         (6),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_alu_a     (alu_a),
    .o_alu_b     (alu_b),
    .o_alu_op    (alu_op),
    .i_alu_result(alu_result),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .i_tx_done   (tx_done),
    .o_busy      (busy),
    .o_op_error  (op_error),
    .o_timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational ALU
  always_comb begin
    case (alu_op)
      6'h20:   alu_result = alu_a + alu_b;
      6'h22:   alu_result = alu_a - alu_b;
      6'h24:   alu_result = alu_a & alu_b;
      6'h25:   alu_result = alu_a | alu_b;
      6'h26:   alu_result = alu_a ^ alu_b;
      6'h03:   alu_result = 8'($signed(alu_a) >>> alu_b);
      6'h02:   alu_result = alu_a >> alu_b;
      6'h27:   alu_result = ~(alu_a | alu_b);
      default: alu_result = 8'h00;
    endcase
  end

  always @(posedge clk) if (tx_start) start_cnt <= start_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  // Sends a valid frame and checks the start pulse lands exactly two cycles after the opcode.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [7:0] exp_res, input string tag);
    int s0;
    s0 = start_cnt;
    send_byte(a);
    send_byte(b);
    send_byte(op);
    chk({tag, "_op"}, alu_op, op[5:0]);
    chk({tag, "_exec_nostart"}, tx_start, 0);
    chk({tag, "_exec_busy"}, busy, 1);
    @(negedge clk);
    chk({tag, "_send_start"}, tx_start, 1);
    chk({tag, "_txdata"}, tx_data, exp_res);
    @(negedge clk);
    chk({tag, "_waittx_nostart"}, tx_start, 0);
    repeat (3) @(negedge clk);
    chk({tag, "_waittx_busy"}, busy, 1);
    chk({tag, "_one_start"}, start_cnt - s0, 1);
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_done  = 1'b0;
    #12;
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_tx", tx_data, 0);
    chk("rst_flags", {tx_start, busy, op_error, timeout}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(8'h07, 8'h05, 8'h20, 8'h0C, "add");
    pulse_done();
    chk("add_idle", busy, 0);

    run_frame(8'h80, 8'h02, 8'h03, 8'hE0, "sra");
    pulse_done();
    run_frame(8'h80, 8'h02, 8'h02, 8'h20, "srl");
    pulse_done();

    begin : invalid_op
      int s0;
      s0 = start_cnt;
      send_byte(8'h10);
      send_byte(8'h01);
      send_byte(8'h01);
      chk("inv_err", op_error, 1);
      chk("inv_busy", busy, 0);
      chk("inv_op_kept", alu_op, 6'h02);
      repeat (4) @(negedge clk);
      chk("inv_nostart", start_cnt - s0, 0);
      send_byte(8'h33);
      chk("inv_next_a", alu_a, 8'h33);
      chk("inv_err_clr", op_error, 0);
      send_byte(8'h01);
      send_byte(8'h20);
      @(negedge clk);
      chk("inv_next_tx", tx_data, 8'h34);
      pulse_done();
    end

    run_frame(8'h04, 8'h04, 8'h26, 8'h00, "xor");
    send_byte(8'h55);
    chk("drop_a", alu_a, 8'h04);
    chk("drop_busy", busy, 1);
    pulse_done();
    run_frame(8'h01, 8'h02, 8'h20, 8'h03, "after_drop");
    chk("after_drop_a", alu_a, 8'h01);
    pulse_done();

    send_byte(8'h09);
`ifdef ALU_SEQ_TIMEOUT_EN
    begin : timeout_path
      int early;
      early = 0;
      repeat (99) begin
        @(negedge clk);
        if (timeout) early++;
      end
      chk("to_not_early", early, 0);
      @(negedge clk);
      chk("to_pulse", timeout, 1);
      @(negedge clk);
      chk("to_pulse_end", timeout, 0);
      send_byte(8'h0A);
      chk("to_next_a", alu_a, 8'h0A);
    end
`else
    begin : no_timeout
      int seen;
      seen = 0;
      repeat (1000) begin
        @(negedge clk);
        if (timeout) seen++;
      end
      chk("noto_none", seen, 0);
    end
`endif
    send_byte(8'h03);
    chk("to_b", alu_b, 8'h03);
    send_byte(8'h25);
    @(negedge clk);
    chk("to_tx", tx_data, 8'h0B);
    pulse_done();

    send_byte(8'h07);
    send_byte(8'h05);
    send_byte(8'h20);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_start", tx_start, 0);
    chk("arst_tx", tx_data, 0);
    chk("arst_a", alu_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(8'h07, 8'h05, 8'h20, 8'h0C, "post_rst");
    pulse_done();
    chk("post_rst_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
